mandelbrot_frame_scheduler: RTL

MANDELBROT_FRAME_SCHEDULER -- requirements
Module: mandelbrot_frame_scheduler

---
 rtl/mandelbrot_frame_scheduler.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/mandelbrot_frame_scheduler.sv
// Mandelbrot frame scheduler: walks the complex-plane grid of one frame,
// issues one point per cycle to the iteration accelerator, forwards the
// accelerator's results to the pixel sink and counts them until the frame
// has fully drained.
module mandelbrot_frame_scheduler #(
  parameter int H_RES = 640,  // pixels per line (2..1023)
  parameter int V_RES = 480   // lines per frame (1..1023)
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] re_start,
  input  logic [31:0] im_start,
  input  logic [31:0] re_delta,
  input  logic [31:0] im_delta,
  // point issue towards the accelerator
  output logic [31:0] real_part_out,
  output logic [31:0] imaginary_part_out,
  output logic [9:0]  x_coord_out,
  output logic [9:0]  y_coord_out,
  output logic        data_in_write,
  input  logic        data_in_full,
  // accelerator result port (show-ahead)
  input  logic [9:0]  acc_x,
  input  logic [9:0]  acc_y,
  input  logic [10:0] acc_iter,
  input  logic        acc_in_set,
  input  logic        acc_available,
  output logic        acc_read,
  // result stream towards the pixel sink
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic [10:0] pix_iter,
  output logic        pix_in_set,
  // frame status
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [9:0]  X_LAST    = 10'(H_RES - 1);
  localparam logic [9:0]  Y_LAST    = 10'(V_RES - 1);
  localparam logic [19:0] PIX_TOTAL = 20'(H_RES * V_RES);

  state_t      r_state;
  state_t      w_state_next;

  // frame configuration captured on an accepted start
  logic [31:0] r_re_start;
  logic [31:0] r_im_start;
  logic [31:0] r_re_delta;
  logic [31:0] r_im_delta;

  // pixel cursor: next point to be issued
  logic [9:0]  r_x;
  logic [9:0]  r_y;
  logic [31:0] r_re;
  logic [31:0] r_im;

  // registered issue port
  logic [31:0] r_real_out;
  logic [31:0] r_imag_out;
  logic [9:0]  r_x_out;
  logic [9:0]  r_y_out;
  logic        r_write;

  logic [19:0] r_result_count;

  logic        w_start_ok;
  logic        w_issue;
  logic        w_last_pixel;
  logic        w_pop;
  logic        w_count_en;

  assign w_last_pixel = (r_x == X_LAST) && (r_y == Y_LAST);

  // Results are only taken while a frame is in flight; anything that shows
  // up in IDLE stays queued in the accelerator.
  assign w_pop      = acc_available && pix_ready && (r_state != IDLE);
  assign w_count_en = w_pop && ((r_state == ISSUE) || (r_state == DRAIN));

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      // NOTE: clocked state uses non-blocking '<=' so every register samples
      // pre-edge values; blocking '=' here would create ordering races.
      r_state <= w_state_next;
    end
  end

  // Next-state logic and per-cycle issue/accept decisions
  always_comb begin
    // NOTE: every signal written here gets a default first; a missing
    // assignment on any path would infer a latch.
    w_state_next = r_state;
    w_start_ok   = 1'b0;
    w_issue      = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_start_ok   = 1'b1;
          w_state_next = ISSUE;
        end
      end
      ISSUE: begin
        if (!data_in_full) begin
          w_issue = 1'b1;
          if (w_last_pixel) begin
            w_state_next = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (r_result_count >= PIX_TOTAL) begin
          w_state_next = DONE;
        end
      end
      DONE: begin
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Configuration capture, pixel cursor walk and registered issue port
  always_ff @(posedge clock) begin
    if (reset) begin
      r_re_start <= '0;
      r_im_start <= '0;
      r_re_delta <= '0;
      r_im_delta <= '0;
      r_x        <= '0;
      r_y        <= '0;
      r_re       <= '0;
      r_im       <= '0;
      r_real_out <= '0;
      r_imag_out <= '0;
      r_x_out    <= '0;
      r_y_out    <= '0;
      r_write    <= 1'b0;
    end else begin
      r_write <= w_issue;
      if (w_start_ok) begin
        r_re_start <= re_start;
        r_im_start <= im_start;
        r_re_delta <= re_delta;
        r_im_delta <= im_delta;
        r_x        <= '0;
        r_y        <= '0;
        r_re       <= re_start;
        r_im       <= im_start;
      end else if (w_issue) begin
        r_real_out <= r_re;
        r_imag_out <= r_im;
        r_x_out    <= r_x;
        r_y_out    <= r_y;
        if (w_last_pixel) begin
          // frame fully issued: park the cursor back at the frame origin
          r_x  <= '0;
          r_y  <= '0;
          r_re <= r_re_start;
          r_im <= r_im_start;
        end else if (r_x != X_LAST) begin
          r_x  <= r_x + 10'd1;
          r_re <= r_re + r_re_delta;  // two's complement wrap by design
        end else begin
          r_x  <= '0;
          r_re <= r_re_start;
          r_y  <= r_y + 10'd1;
          r_im <= r_im + r_im_delta;
        end
      end
    end
  end

  // Count results handed to the sink during the frame
  always_ff @(posedge clock) begin
    if (reset) begin
      r_result_count <= '0;
    end else if (w_start_ok) begin
      r_result_count <= '0;
    end else if (w_count_en) begin
      r_result_count <= r_result_count + 20'd1;
    end
  end

  assign real_part_out      = r_real_out;
  assign imaginary_part_out = r_imag_out;
  assign x_coord_out        = r_x_out;
  assign y_coord_out        = r_y_out;
  assign data_in_write      = r_write;

  assign acc_read   = w_pop;
  assign pix_valid  = acc_available;
  assign pix_x      = acc_x;
  assign pix_y      = acc_y;
  assign pix_iter   = acc_iter;
  assign pix_in_set = acc_in_set;

  assign busy = (r_state != IDLE);
  assign done = (r_state == DONE);

endmodule
